// File: rtl/getreg_name.sv
// RV64 integer register index -> right-justified ASCII ABI name, one-cycle registered lookup.
// Build option GETREG_NUMERIC_EN adds numeric_sel to select the "x0".."x31" form instead.
module getreg_name #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] idx,
`ifdef GETREG_NUMERIC_EN
  input  logic             numeric_sel,
`endif
  output logic             out_valid,
  output logic [31:0]      name,
  output logic [2:0]       name_len,
  output logic             idx_err
);

  localparam int NAME_BYTES = 4;

  typedef struct packed {
    logic                      err;
    logic [2:0]                len;
    logic [NAME_BYTES*8-1:0]   chars;
  } entry_t;

  localparam entry_t ILLEGAL_ENTRY = '{err: 1'b1, len: 3'd1, chars: 32'h0000_003F};

  // Formats a one-letter prefix plus a 0..31 decimal suffix; suffixes >= 10 need a third byte.
  function automatic entry_t fmt_name(input logic [7:0] letter, input logic [4:0] num);
    entry_t     e;
    logic [4:0] tens;
    logic [4:0] ones;
    if (num >= 5'd30) begin
      tens = 5'd3;
    end else if (num >= 5'd20) begin
      tens = 5'd2;
    end else if (num >= 5'd10) begin
      tens = 5'd1;
    end else begin
      tens = 5'd0;
    end
    ones  = num - (tens * 5'd10);
    e.err = 1'b0;
    if (tens == 5'd0) begin
      e.len   = 3'd2;
      e.chars = {16'h0000, letter, 8'h30 + {3'b000, ones}};
    end else begin
      e.len   = 3'd3;
      e.chars = {8'h00, letter, 8'h30 + {3'b000, tens}, 8'h30 + {3'b000, ones}};
    end
    return e;
  endfunction

  // x8 is always reported as s0, never as the frame-pointer alias.
  function automatic entry_t abi_name(input logic [4:0] i);
    entry_t e;
    case (i) inside
      5'd0:           e = '{err: 1'b0, len: 3'd4, chars: 32'h7A65_726F};
      5'd1:           e = '{err: 1'b0, len: 3'd2, chars: 32'h0000_7261};
      5'd2:           e = '{err: 1'b0, len: 3'd2, chars: 32'h0000_7370};
      5'd3:           e = '{err: 1'b0, len: 3'd2, chars: 32'h0000_6770};
      5'd4:           e = '{err: 1'b0, len: 3'd2, chars: 32'h0000_7470};
      [5'd5:5'd7]:    e = fmt_name(8'h74, i - 5'd5);
      [5'd8:5'd9]:    e = fmt_name(8'h73, i - 5'd8);
      [5'd10:5'd17]:  e = fmt_name(8'h61, i - 5'd10);
      [5'd18:5'd27]:  e = fmt_name(8'h73, i - 5'd16);
      [5'd28:5'd31]:  e = fmt_name(8'h74, i - 5'd25);
      default:        e = ILLEGAL_ENTRY;
    endcase
    return e;
  endfunction

  logic             illegal_s;
  entry_t           decode_s;
  logic             out_valid_r;
  logic [31:0]      name_r;
  logic [2:0]       name_len_r;
  logic             idx_err_r;

  assign illegal_s = |idx[IDX_W-1:5];

  // Combinational table decode of the incoming index.
  always_comb begin
    decode_s = ILLEGAL_ENTRY;
    if (illegal_s) begin
      decode_s = ILLEGAL_ENTRY;
    end else begin
`ifdef GETREG_NUMERIC_EN
      if (numeric_sel) begin
        decode_s = fmt_name(8'h78, idx[4:0]);
      end else begin
        decode_s = abi_name(idx[4:0]);
      end
`else
      decode_s = abi_name(idx[4:0]);
`endif
    end
  end

  // Output registers: valid pulses per request, payload holds between requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      name_r      <= 32'h0000_0000;
      name_len_r  <= 3'd0;
      idx_err_r   <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        name_r     <= decode_s.chars;
        name_len_r <= decode_s.len;
        idx_err_r  <= decode_s.err;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign name      = name_r;
  assign name_len  = name_len_r;
  assign idx_err   = idx_err_r;

endmodule

// File: tb/tb_getreg_name.sv
// Directed scoreboard bench for getreg_name; expected names come from a string table model.
module tb_getreg_name;

  typedef struct packed {
    logic        err;
    logic [2:0]  len;
    logic [31:0] chars;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  idx;
`ifdef GETREG_NUMERIC_EN
  logic        numeric_sel;
`endif
  logic        out_valid;
  logic [31:0] name;
  logic [2:0]  name_len;
  logic        idx_err;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  exp_t last_exp;

  string abi [32] = '{"zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
                      "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
                      "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
                      "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};

  getreg_name dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .idx       (idx),
`ifdef GETREG_NUMERIC_EN
    .numeric_sel(numeric_sel),
`endif
    .out_valid (out_valid),
    .name      (name),
    .name_len  (name_len),
    .idx_err   (idx_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [5:0] i, input logic ns);
    exp_t  e;
    string s;
    if (i >= 6'd32) begin
      e.err = 1'b1; e.len = 3'd1; e.chars = 32'h0000_003F;
    end else begin
      s = ns ? $sformatf("x%0d", i) : abi[i];
      e.err   = 1'b0;
      e.len   = 3'(s.len());
      e.chars = 32'h0;
      for (int k = 0; k < s.len(); k++) e.chars = {e.chars[23:0], s[k]};
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic v, input exp_t e);
    chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, v});
    chk({tag, ".name"}, name, e.chars);
    chk({tag, ".name_len"}, {29'h0, name_len}, {29'h0, e.len});
    chk({tag, ".idx_err"}, {31'h0, idx_err}, {31'h0, e.err});
  endtask

  // One clock of stimulus; result of this request is checked just after the edge.
  task automatic cycle(input string tag, input logic v, input logic [5:0] i, input logic ns);
    exp_t e;
    in_valid = v;
    idx      = i;
`ifdef GETREG_NUMERIC_EN
    numeric_sel = ns;
`endif
    if (v) exp_q.push_back(model(i, ns));
    @(posedge clk); #1;
    if (v) begin
      e = exp_q.pop_front();
      last_exp = e;
    end else begin
      e = last_exp;
    end
    chk_outputs(tag, v, e);
  endtask

  initial begin
    last_exp = '0;
    reset    = 1'b0;
    in_valid = 1'b1;
    idx      = 6'h2A;
`ifdef GETREG_NUMERIC_EN
    numeric_sel = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_outputs("in_reset", 1'b0, '0);
    in_valid = 1'b0;
    reset    = 1'b1;
    cycle("post_reset_idle", 1'b0, 6'd3, 1'b0);

    cycle("idx0", 1'b1, 6'd0, 1'b0);
    chk("zero_literal", name, 32'h7A65_726F);

    cycle("b2b_ra", 1'b1, 6'd1, 1'b0);
    chk("ra_literal", name, 32'h0000_7261);
    cycle("b2b_s0", 1'b1, 6'd8, 1'b0);
    chk("s0_literal", name, 32'h0000_7330);
    cycle("b2b_s11", 1'b1, 6'd27, 1'b0);
    chk("s11_literal", name, 32'h0073_3131);
    cycle("b2b_t6", 1'b1, 6'd31, 1'b0);
    chk("t6_literal", name, 32'h0000_7436);

    for (int i = 0; i < 32; i++) cycle($sformatf("sweep%0d", i), 1'b1, 6'(i), 1'b0);

    cycle("illegal40", 1'b1, 6'd40, 1'b0);
    chk("q_literal", name, 32'h0000_003F);
    cycle("idle_hold", 1'b0, 6'd2, 1'b0);
    cycle("idle_hold2", 1'b0, 6'd9, 1'b0);
    cycle("illegal32", 1'b1, 6'd32, 1'b0);
    cycle("legal_after_err", 1'b1, 6'd26, 1'b0);
    cycle("illegal63", 1'b1, 6'd63, 1'b0);

    cycle("pre_reset_t0", 1'b1, 6'd5, 1'b0);
    in_valid = 1'b1;
    idx      = 6'd6;
    #2 reset = 1'b0;
    #1;
    chk_outputs("async_reset", 1'b0, '0);
    @(posedge clk); #1;
    exp_q.delete();
    last_exp = '0;
    in_valid = 1'b0;
    reset    = 1'b1;
    cycle("no_pulse_after_reset", 1'b0, 6'd6, 1'b0);
    cycle("resume_s1", 1'b1, 6'd9, 1'b0);

`ifdef GETREG_NUMERIC_EN
    cycle("num_x5", 1'b1, 6'd5, 1'b1);
    chk("x5_literal", name, 32'h0000_7835);
    cycle("num_x25", 1'b1, 6'd25, 1'b1);
    chk("x25_literal", name, 32'h0078_3235);
    for (int i = 0; i < 32; i++) cycle($sformatf("nsweep%0d", i), 1'b1, 6'(i), 1'b1);
    cycle("num_illegal", 1'b1, 6'd50, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
